// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: datapath width, opcode values, opclass codes
// and the per-class register-usage rules.
package rv32i_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_AW       = 5;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OPIMM   = 4'd7,
    OC_OP      = 4'd8,
    OC_FENCE   = 4'd9,
    OC_SYSTEM  = 4'd10,
    OC_ILLEGAL = 4'd15
  } opclass_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Every valid opcode ends in 2'b11, so compressed encodings fall to ILLEGAL.
  function automatic opclass_e decode_opclass(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    return OC_LUI;
      OPC_AUIPC:  return OC_AUIPC;
      OPC_JAL:    return OC_JAL;
      OPC_JALR:   return OC_JALR;
      OPC_BRANCH: return OC_BRANCH;
      OPC_LOAD:   return OC_LOAD;
      OPC_STORE:  return OC_STORE;
      OPC_OPIMM:  return OC_OPIMM;
      OPC_OP:     return OC_OP;
      OPC_FENCE:  return OC_FENCE;
      OPC_SYSTEM: return OC_SYSTEM;
      default:    return OC_ILLEGAL;
    endcase
  endfunction

  function automatic logic uses_rs1(input opclass_e oc);
    return oc inside {OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE, OC_OPIMM, OC_OP};
  endfunction

  function automatic logic uses_rs2(input opclass_e oc);
    return oc inside {OC_BRANCH, OC_STORE, OC_OP};
  endfunction

  function automatic logic writes_rd(input opclass_e oc);
    return oc inside {OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_LOAD, OC_OPIMM, OC_OP};
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B/U/J field layout for the opclass and
// sign-extends it to XLEN; formats without an immediate yield zero.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  opclass_e        opclass,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (opclass)
      OC_JALR, OC_LOAD, OC_OPIMM, OC_FENCE, OC_SYSTEM:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      OC_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OC_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OC_LUI, OC_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      OC_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/id_stage.sv
// Decode stage: field decode, writeback bypass, load-use hazard detection and
// the ID/EX pipeline register with valid/ready handshaking.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  output logic [REG_AW-1:0] rf_rd_addr0,
  output logic [REG_AW-1:0] rf_rd_addr1,
  input  logic [XLEN-1:0]   rf_rd_dout0,
  input  logic [XLEN-1:0]   rf_rd_dout1,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_opclass,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_we
);

  logic [REG_AW-1:0] rs1, rs2, rd;
  opclass_e          oc;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              we_dec, hazard, adv;

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];
  assign oc  = decode_opclass(if_instr[6:0]);

  assign rf_rd_addr0 = rs1;
  assign rf_rd_addr1 = rs2;

  assign we_dec = writes_rd(oc) && (rd != '0);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (if_instr),
    .opclass (oc),
    .imm     (imm)
  );

  // Writeback data landing this cycle wins over the stale register file read.
  always_comb begin
    rs1_val = rf_rd_dout0;
    if (rs1 == '0)
      rs1_val = '0;
    else if (wb_we && (wb_rd == rs1))
      rs1_val = wb_data;
    rs2_val = rf_rd_dout1;
    if (rs2 == '0)
      rs2_val = '0;
    else if (wb_we && (wb_rd == rs2))
      rs2_val = wb_data;
  end

  assign hazard = ex_valid && (ex_opclass == 4'(OC_LOAD)) && (ex_rd != '0) &&
                  ((uses_rs1(oc) && (ex_rd == rs1)) || (uses_rs2(oc) && (ex_rd == rs2)));
  assign adv      = !ex_valid || ex_ready;
  assign if_ready = rst && adv && !hazard && !flush;

  // ID/EX register: capture, bubble, or hold under downstream back-pressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
      ex_opclass  <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_we       <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      if (if_valid && !hazard) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_rs1_val  <= rs1_val;
        ex_rs2_val  <= rs2_val;
        ex_imm      <= imm;
        ex_rd       <= rd;
        ex_opclass  <= 4'(oc);
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_we       <= we_dec;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: constant decode vectors, directed hazard/bypass/stall/
// reset sequences and a random run against a behavioural pipeline model.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rf_rd_addr0, rf_rd_addr1;
  logic [31:0] rf_rd_dout0, rf_rd_dout1;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_opclass;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_we;

  logic [31:0] regs [32];
  assign rf_rd_dout0 = regs[rf_rd_addr0];
  assign rf_rd_dout1 = regs[rf_rd_addr1];

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_dout0(rf_rd_dout0), .rf_rd_dout1(rf_rd_dout1), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opclass(ex_opclass), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_we(ex_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  oc;
    logic [31:0] imm;
    logic        we;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rd;
    logic [3:0]  oc;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
  } st_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  oc;
    logic [31:0] imm;
    logic        we;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  st_t  m;
  logic m_rst;
  logic seen_ready;
  logic [4:0] seen_a0, seen_a1;
  vec_t vecs [$];
  logic [6:0] opcs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference decode from the ISA tables, immediates built arithmetically.
  function automatic dec_t ref_decode(input logic [31:0] in);
    dec_t   d;
    longint v;
    logic [6:0] opc;
    opc = in[6:0];
    case (opc)
      7'h37: d.oc = 4'd0;
      7'h17: d.oc = 4'd1;
      7'h6F: d.oc = 4'd2;
      7'h67: d.oc = 4'd3;
      7'h63: d.oc = 4'd4;
      7'h03: d.oc = 4'd5;
      7'h23: d.oc = 4'd6;
      7'h13: d.oc = 4'd7;
      7'h33: d.oc = 4'd8;
      7'h0F: d.oc = 4'd9;
      7'h73: d.oc = 4'd10;
      default: d.oc = 4'd15;
    endcase
    v = 0;
    if (d.oc inside {4'd3, 4'd5, 4'd7, 4'd9, 4'd10}) begin
      v = longint'(in[31:20]);
      if (in[31]) v -= 4096;
    end else if (d.oc == 4'd6) begin
      v = longint'(in[31:25]) * 32 + longint'(in[11:7]);
      if (in[31]) v -= 4096;
    end else if (d.oc == 4'd4) begin
      v = longint'(in[31]) * 4096 + longint'(in[7]) * 2048 +
          longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2;
      if (in[31]) v -= 8192;
    end else if (d.oc inside {4'd0, 4'd1}) begin
      v = longint'(in[31:12]) * 4096;
      if (in[31]) v -= (longint'(1) << 32);
    end else if (d.oc == 4'd2) begin
      v = longint'(in[31]) * 1048576 + longint'(in[19:12]) * 4096 +
          longint'(in[20]) * 2048 + longint'(in[30:21]) * 2;
      if (in[31]) v -= 2097152;
    end
    d.imm = v[31:0];
    d.we  = (d.oc inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8}) && (in[11:7] != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && (wb_rd == r)) return wb_data;
    return regs[r];
  endfunction

  // One clock: check combinational outputs mid-cycle, advance the model, check ID/EX.
  task automatic tick();
    dec_t d;
    st_t  nx;
    logic [4:0] r1, r2, rdf;
    logic u1, u2, hz, adv, rdy;
    @(negedge clk);
    r1 = if_instr[19:15];
    r2 = if_instr[24:20];
    rdf = if_instr[11:7];
    seen_a0 = rf_rd_addr0;
    seen_a1 = rf_rd_addr1;
    seen_ready = if_ready;
    chk("rf_rd_addr0", 32'(rf_rd_addr0), 32'(r1));
    chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(r2));
    d  = ref_decode(if_instr);
    u1 = d.oc inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    u2 = d.oc inside {4'd4, 4'd6, 4'd8};
    hz = m.valid && (m.oc == 4'd5) && (m.rd != 5'd0) &&
         ((u1 && (m.rd == r1)) || (u2 && (m.rd == r2)));
    adv = !m.valid || ex_ready;
    rdy = rst && adv && !hz && !flush;
    chk("if_ready", 32'(if_ready), 32'(rdy));
    nx = m;
    if (!rst) nx = '0;
    else if (flush) nx.valid = 1'b0;
    else if (adv) begin
      if (if_valid && rdy) begin
        nx.valid = 1'b1; nx.pc = if_pc; nx.v1 = opnd(r1); nx.v2 = opnd(r2);
        nx.imm = d.imm; nx.rd = rdf; nx.oc = d.oc; nx.f3 = if_instr[14:12];
        nx.f7 = if_instr[30]; nx.we = d.we;
      end else nx.valid = 1'b0;
    end
    m_rst = !rst;
    @(posedge clk);
    #1;
    if (wb_we && (wb_rd != 5'd0)) regs[wb_rd] = wb_data;
    m = nx;
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    if (m.valid || m_rst) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_val", ex_rs1_val, m.v1);
      chk("ex_rs2_val", ex_rs2_val, m.v2);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("ex_opclass", 32'(ex_opclass), 32'(m.oc));
      chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
      chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m.f7));
      chk("ex_we", 32'(ex_we), 32'(m.we));
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] instr, input logic rdy);
    if_valid = v; if_instr = instr; if_pc = $urandom(); ex_ready = rdy;
    flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  localparam logic [31:0] I_ADDI = 32'h0070_0293;
  localparam logic [31:0] I_SW   = 32'hFE51_2E23;
  localparam logic [31:0] I_LW   = 32'h0001_2283;
  localparam logic [31:0] I_ADD  = 32'h0052_8333;

  initial begin
    logic [31:0] instr;
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    regs[0] = 32'hFFFF_FFFF;
    m = '0;
    m_rst = 1'b0;
    rst = 1'b0;
    set_in(1'b0, 32'd0, 1'b1);
    tick();
    tick();
    rst = 1'b1;

    vecs.push_back(vec_t'{I_ADDI,        4'd7,  32'd7,         1'b1});
    vecs.push_back(vec_t'{I_SW,          4'd6,  32'hFFFF_FFFC, 1'b0});
    vecs.push_back(vec_t'{I_LW,          4'd5,  32'd0,         1'b1});
    vecs.push_back(vec_t'{I_ADD,         4'd8,  32'd0,         1'b1});
    vecs.push_back(vec_t'{32'h1234_50B7, 4'd0,  32'h1234_5000, 1'b1});
    vecs.push_back(vec_t'{32'hFFFF_F017, 4'd1,  32'hFFFF_F000, 1'b0});
    vecs.push_back(vec_t'{32'hFF9F_F0EF, 4'd2,  32'hFFFF_FFF8, 1'b1});
    vecs.push_back(vec_t'{32'h0000_8067, 4'd3,  32'd0,         1'b0});
    vecs.push_back(vec_t'{32'h0020_8863, 4'd4,  32'd16,        1'b0});
    vecs.push_back(vec_t'{32'hFE00_1FE3, 4'd4,  32'hFFFF_FFFE, 1'b0});
    vecs.push_back(vec_t'{32'h0FF0_000F, 4'd9,  32'd255,       1'b0});
    vecs.push_back(vec_t'{32'h0000_0073, 4'd10, 32'd0,         1'b0});
    vecs.push_back(vec_t'{32'h0000_0000, 4'd15, 32'd0,         1'b0});
    vecs.push_back(vec_t'{32'h0070_0290, 4'd15, 32'd0,         1'b0});
    vecs.push_back(vec_t'{32'h0000_005B, 4'd15, 32'd0,         1'b0});
    vecs.push_back(vec_t'{32'hFFF0_0393, 4'd7,  32'hFFFF_FFFF, 1'b1});

    foreach (vecs[i]) begin
      set_in(1'b0, 32'd0, 1'b1);
      tick();
      set_in(1'b1, vecs[i].instr, 1'b1);
      tick();
      chk($sformatf("vec%0d valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("vec%0d opclass", i), 32'(ex_opclass), 32'(vecs[i].oc));
      chk($sformatf("vec%0d imm", i), ex_imm, vecs[i].imm);
      chk($sformatf("vec%0d we", i), 32'(ex_we), 32'(vecs[i].we));
    end

    // addi fields and sw read addresses
    set_in(1'b0, 32'd0, 1'b1); tick();
    set_in(1'b1, I_ADDI, 1'b1); tick();
    chk("addi rd", 32'(ex_rd), 32'd5);
    chk("addi rs1_val", ex_rs1_val, 32'd0);
    set_in(1'b1, I_SW, 1'b1); tick();
    chk("sw addr0", 32'(seen_a0), 32'd2);
    chk("sw addr1", 32'(seen_a1), 32'd5);

    // load-use: one bubble, then consumer accepted with bypassed writeback
    set_in(1'b0, 32'd0, 1'b1); tick();
    set_in(1'b1, I_LW, 1'b1); tick();
    chk("lw accepted", 32'(seen_ready), 32'd1);
    set_in(1'b1, I_ADD, 1'b1); tick();
    chk("hazard if_ready", 32'(seen_ready), 32'd0);
    chk("hazard bubble", 32'(ex_valid), 32'd0);
    set_in(1'b1, I_ADD, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    chk("post-hazard if_ready", 32'(seen_ready), 32'd1);
    chk("post-hazard valid", 32'(ex_valid), 32'd1);
    chk("post-hazard opclass", 32'(ex_opclass), 32'd8);
    chk("bypass rs1", ex_rs1_val, 32'hDEAD_BEEF);
    chk("bypass rs2", ex_rs2_val, 32'hDEAD_BEEF);
    regs[5] = 32'h1234_5678;
    set_in(1'b1, I_ADD, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hCAFE_F00D;
    tick();
    chk("no-bypass rs1", ex_rs1_val, 32'h1234_5678);
    chk("no-bypass rs2", ex_rs2_val, 32'h1234_5678);

    // back-pressure stall, then flush while stalled
    set_in(1'b0, 32'd0, 1'b1); tick();
    set_in(1'b1, I_ADDI, 1'b1); tick();
    set_in(1'b1, I_ADD, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall if_ready", 32'(seen_ready), 32'd0);
      chk("stall valid", 32'(ex_valid), 32'd1);
      chk("stall imm", ex_imm, 32'd7);
      chk("stall rd", 32'(ex_rd), 32'd5);
      chk("stall opclass", 32'(ex_opclass), 32'd7);
    end
    flush = 1'b1;
    tick();
    chk("flush in stall", 32'(ex_valid), 32'd0);

    // reset during a stall, then an all-zero (illegal) word
    set_in(1'b1, I_ADDI, 1'b1); tick();
    set_in(1'b1, I_ADD, 1'b0); tick();
    rst = 1'b0;
    tick();
    chk("reset if_ready", 32'(seen_ready), 32'd0);
    chk("reset valid", 32'(ex_valid), 32'd0);
    chk("reset imm", ex_imm, 32'd0);
    rst = 1'b1;
    set_in(1'b1, 32'd0, 1'b1); tick();
    chk("illegal valid", 32'(ex_valid), 32'd1);
    chk("illegal opclass", 32'(ex_opclass), 32'd15);
    chk("illegal we", 32'(ex_we), 32'd0);

    // random traffic with small register indices to provoke hazards/bypass
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23,
             7'h13, 7'h33, 7'h0F, 7'h73, 7'h5B, 7'h00};
    for (int n = 0; n < 400; n++) begin
      instr = $urandom();
      instr[6:0]   = opcs[$urandom_range(0, 13)];
      instr[11:7]  = 5'($urandom_range(0, 3));
      instr[19:15] = 5'($urandom_range(0, 3));
      instr[24:20] = 5'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 49) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      if_valid = ($urandom_range(0, 9) < 7);
      ex_ready = ($urandom_range(0, 3) != 0);
      if_instr = instr;
      if_pc    = $urandom();
      wb_we    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; all *_pc, *_val, imm, data ports are XLEN bits.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 if_valid  in  1  fetch presents an instruction. if_instr  in  32  instruction word. if_pc  in  XLEN  its PC.
REQ-005 if_ready  out  1  stage accepts the fetch beat this cycle.
REQ-006 rf_rd_addr0, rf_rd_addr1  out  5  register file read addresses (rs1, rs2); rf_rd_dout0, rf_rd_dout1  in  XLEN  asynchronous read data.
REQ-007 wb_we  in  1, wb_rd  in  5, wb_data  in  XLEN  writeback port (same values driven into the register file write port).
REQ-008 flush  in  1  kill the instruction in the ID/EX register and any incoming beat.
REQ-009 ex_ready  in  1  execute accepts the ID/EX beat. ex_valid  out  1  ID/EX beat valid.
REQ-010 ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN; ex_rd  out  5; ex_opclass  out  4; ex_funct3  out  3; ex_funct7b5  out  1; ex_we  out  1  (writes rd).

Function
REQ-011 rf_rd_addr0 = if_instr[19:15], rf_rd_addr1 = if_instr[24:20], combinational, regardless of if_valid.
REQ-012 Opclass decode from if_instr[6:0]: LUI 0, AUIPC 1, JAL 2, JALR 3, BRANCH 4, LOAD 5, STORE 6, OPIMM 7, OP 8, FENCE 9, SYSTEM 10; any other opcode, or instr[1:0] != 2'b11, is ILLEGAL 15.
REQ-013 Immediate sign-extended to XLEN per I/S/B/U/J format of the opclass; R-type, ILLEGAL -> 0; B and J immediates have bit 0 = 0.
REQ-014 ex_we = 1 only for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP with rd != 0; else 0.
REQ-015 Bypass: if wb_we and wb_rd != 0 and wb_rd equals the rs field, captured operand = wb_data instead of register file data; rs = 0 always yields 0.
REQ-016 rs1 used by JALR, BRANCH, LOAD, STORE, OPIMM, OP; rs2 used by BRANCH, STORE, OP.
REQ-017 Load-use hazard = ex_valid and ex_opclass == LOAD and ex_rd != 0 and ex_rd matches a used rs field of if_instr.
REQ-018 Advance condition adv = !ex_valid or ex_ready.
REQ-019 if_ready = adv and !hazard and !flush.
REQ-020 On if_valid and if_ready: ID/EX register captures all decoded fields, ex_valid <= 1; latency one cycle.
REQ-021 adv and (hazard or !if_valid): ex_valid <= 0 (bubble), data fields may hold.
REQ-022 !adv: all ID/EX outputs hold exactly (stall).
REQ-023 flush: ex_valid <= 0 next edge, overrides REQ-020..022; no beat accepted that cycle.
REQ-024 Hazard stalls exactly one cycle: after the bubble the LOAD has left ID/EX, so the consumer is accepted next cycle with the bypassed value when writeback coincides.

Reset
REQ-025 rst low at a rising edge: ex_valid <= 0, ex_pc/ex_rs1_val/ex_rs2_val/ex_imm <= 0, ex_rd <= 0, ex_opclass <= 0, ex_funct3 <= 0, ex_funct7b5 <= 0, ex_we <= 0.
REQ-026 While rst is low if_ready = 0; reset mid-stall discards the held beat.

Structure
REQ-027 Opclass codes, opcode constants and XLEN default in shared package rv32i_pkg.
REQ-028 One sub-module, imm_gen (combinational: instr, opclass -> imm); decode, hazard, bypass and ID/EX register live in id_stage.

Verification
REQ-029 addi x5,x0,7 (0x00700293), ex_ready=1 -> next cycle ex_valid=1, opclass 7, rd 5, imm 7, ex_we 1, rs1_val 0.
REQ-030 sw x5,-4(x2) (0xFE512E23) -> imm 0xFFFFFFFC, opclass 6, ex_we 0, rf_rd_addr0=2, rf_rd_addr1=5.
REQ-031 lw x5,0(x2) (0x00012283) then add x6,x5,x5 (0x00528333) -> if_ready low one cycle, one bubble (ex_valid 0), add accepted next cycle.
REQ-032 add x6,x5,x5 with wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> ex_rs1_val = ex_rs2_val = 0xDEADBEEF; repeat with wb_rd=0 -> register file values.
REQ-033 ex_ready=0 for 3 cycles with valid beat -> outputs stable, if_ready 0; flush asserted during stall -> ex_valid 0 next cycle.
REQ-034 rst low for one edge during stall; instr 0x00000000 (ILLEGAL) -> opclass 15, ex_we 0.
